// File: rtl/peri_sink.sv
// peri_sink: decodes core peripheral writes into DATA_OUT FIFO, LED, DONE and CLEAR registers.
// Optional write counter output wr_count is enabled by defining PERI_SINK_WCOUNT_EN.
module peri_sink #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] BASE_ADDR  = 16'hFF00
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          peri_web,
  input  logic [15:0]                   peri_addr,
  input  logic [15:0]                   peri_datao,
  output logic                          out_valid,
  output logic [15:0]                   out_data,
  input  logic                          out_ready,
  output logic [15:0]                   led,
  output logic                          done,
  output logic [15:0]                   exit_code,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef PERI_SINK_WCOUNT_EN
  ,
  output logic [15:0]                   wr_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [15:0]   led_q, led_d;
  logic [15:0]   exit_code_q, exit_code_d;
  logic          done_q, done_d;
  logic          overflow_q, overflow_d;

  logic [15:0] offset;
  logic        in_win;
  logic        wr_data, wr_led, wr_done, wr_clr;
  logic        full, pop, push;

  // Subtracting the base keeps the decode correct for unaligned BASE_ADDR values.
  always_comb begin
    offset  = peri_addr - BASE_ADDR;
    in_win  = !peri_web && (offset[15:2] == 14'd0);
    wr_data = in_win && (offset[1:0] == 2'd0);
    wr_led  = in_win && (offset[1:0] == 2'd1);
    wr_done = in_win && (offset[1:0] == 2'd2);
    wr_clr  = in_win && (offset[1:0] == 2'd3);
    full    = (count_q == FULL_CNT);
    pop     = (count_q != '0) && out_ready;
    push    = wr_data && (!full || pop);
  end

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    led_d       = led_q;
    done_d      = done_q;
    exit_code_d = exit_code_q;
    overflow_d  = overflow_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;

    if (wr_data && full && !pop) overflow_d = 1'b1;
    if (wr_led) led_d = peri_datao;
    if (wr_done && !done_q) begin
      done_d      = 1'b1;
      exit_code_d = peri_datao;
    end

    // CLEAR overrides a concurrent pop; the popped word is simply lost.
    if (wr_clr) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      led_q       <= '0;
      done_q      <= 1'b0;
      exit_code_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      led_q       <= led_d;
      done_q      <= done_d;
      exit_code_q <= exit_code_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= peri_datao;
  end

`ifdef PERI_SINK_WCOUNT_EN
  logic [15:0] wr_count_q, wr_count_d;

  always_comb begin
    wr_count_d = wr_count_q;
    if (in_win && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_count_q <= '0;
    else        wr_count_q <= wr_count_d;
  end

  assign wr_count = wr_count_q;
`else
  // Write counter not built in this configuration.
`endif

  assign out_valid  = (count_q != '0);
  assign out_data   = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign led        = led_q;
  assign done       = done_q;
  assign exit_code  = exit_code_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_peri_sink.sv
// Bench for peri_sink: queue-based reference model compared every cycle, plus literal checks.
// Define PERI_SINK_WCOUNT_EN to also cover the wr_count output.
module tb_peri_sink;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        peri_web = 1'b1;
  logic [15:0] peri_addr = '0;
  logic [15:0] peri_datao = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [15:0] led;
  logic        done;
  logic [15:0] exit_code;
  logic        overflow;
  logic [3:0]  fifo_count;
`ifdef PERI_SINK_WCOUNT_EN
  logic [15:0] wr_count;
`endif

  peri_sink #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .peri_web   (peri_web),
    .peri_addr  (peri_addr),
    .peri_datao (peri_datao),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .led        (led),
    .done       (done),
    .exit_code  (exit_code),
    .overflow   (overflow),
    .fifo_count (fifo_count)
`ifdef PERI_SINK_WCOUNT_EN
    ,
    .wr_count   (wr_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue plus plain register variables.
  int          q[$];
  logic [15:0] m_led = '0;
  bit          m_done = 1'b0;
  logic [15:0] m_exit = '0;
  bit          m_ovf = 1'b0;
  int          m_wc = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_led = '0; m_done = 1'b0; m_exit = '0; m_ovf = 1'b0; m_wc = 0;
      end else begin
        bit          popping;
        bit          was_full;
        logic [15:0] off;
        bit          hit;
        popping  = (q.size() > 0) && out_ready;
        was_full = (q.size() == DEPTH);
        off      = peri_addr - BASE;
        hit      = !peri_web && (off < 16'd4);
        if (popping) void'(q.pop_front());
        if (hit) begin
          if (m_wc < 65535) m_wc++;
          case (off)
            16'd0: if (was_full && !popping) m_ovf = 1'b1; else q.push_back(int'(peri_datao));
            16'd1: m_led = peri_datao;
            16'd2: if (!m_done) begin m_done = 1'b1; m_exit = peri_datao; end
            default: begin q.delete(); m_ovf = 1'b0; end
          endcase
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("cmp_count", int'(fifo_count), q.size());
        chk("cmp_valid", int'(out_valid), int'(q.size() > 0));
        if (q.size() > 0) chk("cmp_data", int'(out_data), q[0]);
        chk("cmp_led", int'(led), int'(m_led));
        chk("cmp_done", int'(done), int'(m_done));
        chk("cmp_exit", int'(exit_code), int'(m_exit));
        chk("cmp_ovf", int'(overflow), int'(m_ovf));
`ifdef PERI_SINK_WCOUNT_EN
        chk("cmp_wcount", int'(wr_count), m_wc);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    peri_web = 1'b0; peri_addr = a; peri_datao = d;
    step();
    peri_web = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    started = 1'b1;
    step();
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_led", int'(led), 0);
    chk("rst_done", int'(done), 0);

    // LED write
    wr(BASE + 16'd1, 16'h1234);
    chk("led_1234", int'(led), 16'h1234);
    chk("led_count", int'(fifo_count), 0);
    chk("led_ovf", int'(overflow), 0);

    // Overfill then drain
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) wr(BASE, 16'(i));
    chk("fill_count", int'(fifo_count), 8);
    chk("fill_ovf", int'(overflow), 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_valid", int'(out_valid), 1);
      chk("drain_data", int'(out_data), i);
      step();
    end
    chk("drain_empty", int'(out_valid), 0);

    // Push into a full FIFO while popping, across pointer wrap
    wr(BASE + 16'd3, 16'h0);
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) wr(BASE, 16'h0050 + 16'(i));
    out_ready = 1'b1;
    idle(3);
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) wr(BASE, 16'h0100 + 16'(i));
    chk("full_count", int'(fifo_count), 8);
    out_ready = 1'b1;
    wr(BASE, 16'hAAAA);
    chk("pp_count", int'(fifo_count), 8);
    chk("pp_ovf", int'(overflow), 0);
    for (int i = 2; i <= 8; i++) begin
      chk("wrap_data", int'(out_data), 16'h0100 + i);
      step();
    end
    chk("wrap_last", int'(out_data), 16'hAAAA);
    step();
    chk("wrap_empty", int'(out_valid), 0);

    // DONE is sticky
    wr(BASE + 16'd2, 16'h0005);
    wr(BASE + 16'd2, 16'h0007);
    chk("done_set", int'(done), 1);
    chk("done_exit", int'(exit_code), 16'h0005);

    // CLEAR with 3 entries and overflow set, while popping
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) wr(BASE, 16'h0200 + 16'(i));
    out_ready = 1'b1;
    idle(5);
    out_ready = 1'b0;
    chk("pre_clr_count", int'(fifo_count), 3);
    chk("pre_clr_ovf", int'(overflow), 1);
    out_ready = 1'b1;
    wr(BASE + 16'd3, 16'h0);
    chk("clr_count", int'(fifo_count), 0);
    chk("clr_valid", int'(out_valid), 0);
    chk("clr_ovf", int'(overflow), 0);
    chk("clr_led", int'(led), 16'h1234);
    chk("clr_done", int'(done), 1);

    // Out-of-window writes
    wr(16'h0000, 16'h0099);
    wr(BASE + 16'd4, 16'h0099);
    chk("oow_led", int'(led), 16'h1234);
    chk("oow_count", int'(fifo_count), 0);
    chk("oow_exit", int'(exit_code), 16'h0005);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) wr(BASE, 16'h0300 + 16'(i));
    chk("pre_rst_count", int'(fifo_count), 4);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_count", int'(fifo_count), 0);
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_led", int'(led), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_exit", int'(exit_code), 0);
    chk("arst_ovf", int'(overflow), 0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 1; i <= 5; i++) wr(BASE + 16'd1, 16'(i));
    chk("post_led", int'(led), 5);
`ifdef PERI_SINK_WCOUNT_EN
    chk("wcount_5", int'(wr_count), 5);
`endif

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/peri_sink.md
# peri_sink

Peripheral-side responder for the core's registered peripheral write port (`peri_web`, `peri_addr`, `peri_datao`). It decodes each write into one of four memory-mapped peripheral registers. DATA_OUT writes are buffered in a FIFO and drained by a valid/ready stream toward the pad/test harness. It also holds an LED register, a sticky program-done flag with exit code, and an overflow flag. It sits at chip top, directly on the registered outputs of the core wrapper.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: number of DATA_OUT FIFO entries; must be a power of 2, minimum 2.
- `BASE_ADDR`, default 16'hFF00: base of the 4-word peripheral window.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `peri_web`  in  1  write enable, active low; one write per cycle it is 0.
- `peri_addr`  in  16  write address.
- `peri_datao`  in  16  write data.
- `out_valid`  out  1  FIFO non-empty.
- `out_data`  out  16  FIFO head word.
- `out_ready`  in  1  consumer accepts the head word when it and `out_valid` are both 1.
- `led`  out  16  LED register.
- `done`  out  1  sticky program-complete flag.
- `exit_code`  out  16  data from the first DONE write.
- `overflow`  out  1  sticky; a DATA_OUT write was dropped.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
Address map, decoded when `peri_web`=0:
- `BASE_ADDR+0` DATA_OUT: pushes `peri_datao` into the FIFO. If the FIFO is full and no pop occurs that cycle, the word is dropped and `overflow` is set.
- `BASE_ADDR+1` LED: `led` <= `peri_datao`.
- `BASE_ADDR+2` DONE: if `done`=0, sets `done`=1 and `exit_code` <= `peri_datao`. Later DONE writes are ignored.
- `BASE_ADDR+3` CLEAR: empties the FIFO (pointers and count to 0) and clears `overflow`. It does not affect `led`, `done` or `exit_code`.
- Any other address: the write is ignored with no side effect.

FIFO behaviour:
- Circular buffer with read and write pointers of $clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH, plus a separate count register.
- Pop occurs when `out_valid` && `out_ready`.
- Push and pop in the same cycle leave the count unchanged. This is accepted even when the FIFO is full, so no overflow occurs in that case.
- CLEAR in the same cycle as a pop: CLEAR wins and the popped word is simply discarded.
- Push on an empty FIFO: the word appears as the head on the next cycle.
- `out_data` equals the RAM word at the read pointer. It is don't-care while `out_valid`=0, but must be stable while `out_valid`=1 and `out_ready`=0.

Reset values: `out_valid`=0, `fifo_count`=0, `led`=0, `done`=0, `exit_code`=0, `overflow`=0, pointers 0. Asserting `rst_n` mid-stream discards all FIFO contents immediately and asynchronously. FIFO RAM contents are not reset.

## Timing
- Inputs are sampled at the rising edge; every output is a register or is driven directly from registers.
- Write at edge N: `led`, `done`, `exit_code`, `overflow`, `fifo_count` and `out_valid` update to their new values after edge N. Write-to-visible latency is 1 cycle.
- Pop at edge N: the next head word is presented after edge N.
- Back-to-back writes every cycle and back-to-back pops every cycle are both sustained with no bubbles.
- `out_ready` may toggle freely; no combinational path exists from `out_ready` to `out_valid`.

## Configuration
- `PERI_SINK_WCOUNT_EN`:
  - Defined: adds output `wr_count` (16 bits, reset 0). It increments by 1 on every cycle with `peri_web`=0 whose address decodes into the window (all 4 registers, including dropped DATA_OUT writes). It saturates at 16'hFFFF.
  - Undefined: the port, the counter and its logic are absent.

## Test plan
- Reset, then write 16'h1234 to BASE_ADDR+1 -> `led`=16'h1234 one cycle later; all other outputs remain at reset values.
- With `out_ready`=0, write 9 words 1..9 to DATA_OUT (depth 8) -> `fifo_count`=8 and `overflow`=1. Raise `out_ready` -> 1..8 stream out on consecutive cycles, then `out_valid`=0.
- FIFO full, `out_ready`=1, write 16'hAAAA in the same cycle -> no overflow and `fifo_count` stays 8. 16'hAAAA is output last, including across pointer wrap.
- Write 16'h0005 then 16'h0007 to DONE -> `done`=1 and `exit_code`=16'h0005 held.
- Fill 3 entries with `overflow` set, then write CLEAR while `out_ready`=1 -> next cycle `fifo_count`=0, `out_valid`=0, `overflow`=0, with `led`/`done` unchanged. Writes to 16'h0000 and BASE_ADDR+4 cause no change anywhere.
- Assert `rst_n`=0 mid-stream with 4 entries queued -> all outputs return to reset values immediately. With `PERI_SINK_WCOUNT_EN`, 5 in-window writes -> `wr_count`=5.
